// File: rtl/mem_req_unit_pkg.sv
// rtl/mem_req_unit_pkg.sv - size encodings and FSM states shared by the memory request unit
package mem_req_unit_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_e;

endpackage

// File: rtl/mem_strb_gen.sv
// rtl/mem_strb_gen.sv - misalignment flag, byte strobes and lane-replicated write data
module mem_strb_gen
   import mem_req_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]          size,
   input  logic [2:0]          addr_lo,
   input  logic [DATA_W-1:0]   st_data,
   output logic                ale,
   output logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   wdata
);

   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);

   logic [NB-1:0] mask;
   int            bmask;

   always_comb begin
      ale  = 1'b0;
      mask = '0;
      case (size_e'(size))
         SZ_B: begin ale = 1'b0;        mask = NB'(1);  end
         SZ_H: begin ale = addr_lo[0];  mask = NB'(3);  end
         SZ_W: begin ale = |addr_lo[1:0]; mask = NB'(15); end
         // a 32-bit bus has no way to carry a dword in one beat
         SZ_D: begin ale = (|addr_lo) || (DATA_W == 32); mask = '1; end
         default: ;
      endcase
      wstrb = mask << addr_lo[LB-1:0];

      bmask = (1 << size) - 1;
      wdata = '0;
      for (int i = 0; i < NB; i++) begin
         wdata[8*i +: 8] = st_data[8*(i & bmask) +: 8];
      end
   end

endmodule

// File: rtl/mem_req_unit.sv
// rtl/mem_req_unit.sv - EX-stage memory request issue with outstanding tracking and flush cancel
module mem_req_unit
   import mem_req_unit_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int MAX_OUT = 2,
   localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                op_load,
   input  logic                op_store,
   input  logic [1:0]          op_size,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   st_data,
   input  logic                flush,
   output logic                ale,
   output logic                req,
   output logic                req_wr,
   output logic [1:0]          req_size,
   output logic [ADDR_W-1:0]   req_addr,
   output logic [DATA_W/8-1:0] req_wstrb,
   output logic [DATA_W-1:0]   req_wdata,
   input  logic                addr_ok,
   input  logic                data_ok,
   output logic                resp_valid,
   output logic                resp_cancel,
   output logic [CNT_W-1:0]    outstanding
);

   localparam int NB = DATA_W / 8;

   state_e              state_q, state_d;
   logic                req_wr_q, req_wr_d;
   logic [1:0]          req_size_q, req_size_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [NB-1:0]       req_wstrb_q, req_wstrb_d;
   logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
   logic [CNT_W-1:0]    out_q, out_d;
   logic [CNT_W-1:0]    cancel_q, cancel_d;

   logic                ale_c;
   logic [NB-1:0]       wstrb_c;
   logic [DATA_W-1:0]   wdata_c;
   logic                accept, inc, live;

   mem_strb_gen #(.DATA_W(DATA_W)) u_strb (
      .size    (op_size),
      .addr_lo (addr[2:0]),
      .st_data (st_data),
      .ale     (ale_c),
      .wstrb   (wstrb_c),
      .wdata   (wdata_c)
   );

   always_comb begin
      state_d     = state_q;
      req_wr_d    = req_wr_q;
      req_size_d  = req_size_q;
      req_addr_d  = req_addr_q;
      req_wstrb_d = req_wstrb_q;
      req_wdata_d = req_wdata_q;
      cancel_d    = cancel_q;
      resp_valid  = 1'b0;
      resp_cancel = 1'b0;

      in_ready = (state_q == S_IDLE) && (out_q < CNT_W'(MAX_OUT)) && !flush;
      accept   = in_valid && (op_load || op_store) && in_ready;
      inc      = (state_q == S_REQ) && addr_ok;
      live     = data_ok && (out_q != '0);

      if (!reset && live) begin
         if (cancel_q != '0) resp_cancel = 1'b1;
         else                resp_valid  = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept && !ale_c) begin
               state_d     = S_REQ;
               req_wr_d    = op_store;
               req_size_d  = op_size;
               req_addr_d  = addr;
               req_wstrb_d = op_store ? wstrb_c : '0;
               req_wdata_d = wdata_c;
            end
         end
         S_REQ: begin
            if (addr_ok) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      out_d = out_q + CNT_W'(inc) - CNT_W'(live);

      if (live && cancel_q != '0) cancel_d = cancel_q - CNT_W'(1);
      // every response still owed after this cycle belongs to a flushed op
      if (flush) cancel_d = out_q - CNT_W'(live) + CNT_W'(state_q == S_REQ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         req_wr_q    <= 1'b0;
         req_size_q  <= '0;
         req_addr_q  <= '0;
         req_wstrb_q <= '0;
         req_wdata_q <= '0;
         out_q       <= '0;
         cancel_q    <= '0;
      end else begin
         state_q     <= state_d;
         req_wr_q    <= req_wr_d;
         req_size_q  <= req_size_d;
         req_addr_q  <= req_addr_d;
         req_wstrb_q <= req_wstrb_d;
         req_wdata_q <= req_wdata_d;
         out_q       <= out_d;
         cancel_q    <= cancel_d;
      end
   end

   assign ale         = ale_c;
   assign req         = (state_q == S_REQ);
   assign req_wr      = req_wr_q;
   assign req_size    = req_size_q;
   assign req_addr    = req_addr_q;
   assign req_wstrb   = req_wstrb_q;
   assign req_wdata   = req_wdata_q;
   assign outstanding = out_q;

endmodule
